bp_cfg_responder: RTL and testbench

BP_CFG_RESPONDER -- requirements
Module: bp_cfg_responder

---
 rtl/bp_cfg_responder_pkg.sv | 33 +++
 rtl/bp_cfg_responder.sv | 144 ++++++++++++++
 tb/tb_bp_cfg_responder.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bp_cfg_responder_pkg.sv
// Shared config definitions for the tile config responder: processor parameter struct,
// register address map and responder FSM states.
package bp_cfg_responder_pkg;

    typedef struct packed {
        int unsigned cfg_core_width;
        int unsigned cfg_addr_width;
        int unsigned cfg_data_width;
        int unsigned num_cce_instr_ram_els;
    } bp_proc_param_s;

    localparam bp_proc_param_s bp_cfg_default_p = '{
        cfg_core_width:        8,
        cfg_addr_width:        16,
        cfg_data_width:        32,
        num_cce_instr_ram_els: 256
    };

    typedef enum logic {
        e_ready,
        e_resp
    } bp_cfg_state_e;

    localparam int unsigned bp_cfg_reg_freeze_gp      = 'h0000;
    localparam int unsigned bp_cfg_reg_core_id_gp     = 'h0001;
    localparam int unsigned bp_cfg_reg_icache_mode_gp = 'h0002;
    localparam int unsigned bp_cfg_reg_dcache_mode_gp = 'h0003;
    localparam int unsigned bp_cfg_reg_scratch_gp     = 'h0004;
    localparam int unsigned bp_cfg_reg_ucode_addr_gp  = 'h0010;
    localparam int unsigned bp_cfg_reg_ucode_data_gp  = 'h0011;
    localparam int unsigned bp_cfg_reg_write_count_gp = 'h0020;

endpackage

// File: rtl/bp_cfg_responder.sv
// Config-bus register responder: decodes commands addressed to this tile, holds mode and
// scratch registers, streams CCE microcode writes and returns one read response at a time.
module bp_cfg_responder
    import bp_cfg_responder_pkg::*;
#(
    parameter int unsigned cfg_core_width_p = bp_cfg_default_p.cfg_core_width,
    parameter int unsigned cfg_addr_width_p = bp_cfg_default_p.cfg_addr_width,
    parameter int unsigned cfg_data_width_p = bp_cfg_default_p.cfg_data_width,
    parameter int unsigned ucode_els_p      = bp_cfg_default_p.num_cce_instr_ram_els,
    localparam int unsigned ucode_addr_width_lp = (ucode_els_p > 1) ? $clog2(ucode_els_p) : 1
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic [cfg_core_width_p-1:0]    my_core_id_i,

    input  logic                           cfg_cmd_v_i,
    output logic                           cfg_cmd_ready_o,
    input  logic [cfg_core_width_p-1:0]    cfg_cmd_core_id_i,
    input  logic [cfg_addr_width_p-1:0]    cfg_cmd_addr_i,
    input  logic [cfg_data_width_p-1:0]    cfg_cmd_data_i,
    input  logic                           cfg_cmd_we_i,

    output logic                           cfg_resp_v_o,
    output logic [cfg_data_width_p-1:0]    cfg_resp_data_o,
    input  logic                           cfg_resp_yumi_i,

    output logic                           freeze_o,
    output logic [1:0]                     icache_mode_o,
    output logic [1:0]                     dcache_mode_o,

    output logic                           ucode_w_v_o,
    output logic [ucode_addr_width_lp-1:0] ucode_addr_o,
    output logic [cfg_data_width_p-1:0]    ucode_data_o
);

    bp_cfg_state_e state_q, state_d;

    logic                           freeze_q;
    logic [1:0]                     icache_mode_q, dcache_mode_q;
    logic [cfg_data_width_p-1:0]    scratch_q;
    logic [ucode_addr_width_lp-1:0] ucode_addr_q;
    logic [cfg_data_width_p-1:0]    write_count_q;
    logic [cfg_data_width_p-1:0]    resp_data_q;
    logic                           ucode_w_v_q;
    logic [ucode_addr_width_lp-1:0] ucode_waddr_q;
    logic [cfg_data_width_p-1:0]    ucode_wdata_q;

    logic                           accept, match, wr_v, rd_v;
    logic [cfg_data_width_p-1:0]    rd_data;

    always_comb begin
        accept = cfg_cmd_v_i & cfg_cmd_ready_o;
        match  = (cfg_cmd_core_id_i == my_core_id_i);
        wr_v   = accept & match & cfg_cmd_we_i;
        rd_v   = accept & match & ~cfg_cmd_we_i;
    end

    always_comb begin
        rd_data = '0;
        case (cfg_cmd_addr_i)
            cfg_addr_width_p'(bp_cfg_reg_freeze_gp):      rd_data = cfg_data_width_p'(freeze_q);
            cfg_addr_width_p'(bp_cfg_reg_core_id_gp):     rd_data = cfg_data_width_p'(my_core_id_i);
            cfg_addr_width_p'(bp_cfg_reg_icache_mode_gp): rd_data = cfg_data_width_p'(icache_mode_q);
            cfg_addr_width_p'(bp_cfg_reg_dcache_mode_gp): rd_data = cfg_data_width_p'(dcache_mode_q);
            cfg_addr_width_p'(bp_cfg_reg_scratch_gp):     rd_data = scratch_q;
            cfg_addr_width_p'(bp_cfg_reg_ucode_addr_gp):  rd_data = cfg_data_width_p'(ucode_addr_q);
            cfg_addr_width_p'(bp_cfg_reg_write_count_gp): rd_data = write_count_q;
            default:                                      rd_data = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= e_ready;
        end else begin
            state_q <= state_d;
        end
    end

    // A read accepted alongside yumi keeps the FSM in e_resp with fresh data.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            e_ready: if (rd_v) state_d = e_resp;
            e_resp:  if (cfg_resp_yumi_i) state_d = rd_v ? e_resp : e_ready;
            default: state_d = e_ready;
        endcase
    end

    always_comb begin
        cfg_cmd_ready_o = (state_q == e_ready) | cfg_resp_yumi_i;
        cfg_resp_v_o    = (state_q == e_resp);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            freeze_q      <= 1'b1;
            icache_mode_q <= '0;
            dcache_mode_q <= '0;
            scratch_q     <= '0;
            ucode_addr_q  <= '0;
            write_count_q <= '0;
            resp_data_q   <= '0;
            ucode_w_v_q   <= 1'b0;
            ucode_waddr_q <= '0;
            ucode_wdata_q <= '0;
        end else begin
            ucode_w_v_q <= 1'b0;
            if (rd_v) begin
                resp_data_q <= rd_data;
            end
            if (wr_v) begin
                if (~&write_count_q) begin
                    write_count_q <= write_count_q + cfg_data_width_p'(1);
                end
                case (cfg_cmd_addr_i)
                    cfg_addr_width_p'(bp_cfg_reg_freeze_gp):      freeze_q <= cfg_cmd_data_i[0];
                    cfg_addr_width_p'(bp_cfg_reg_icache_mode_gp): icache_mode_q <= cfg_cmd_data_i[1:0];
                    cfg_addr_width_p'(bp_cfg_reg_dcache_mode_gp): dcache_mode_q <= cfg_cmd_data_i[1:0];
                    cfg_addr_width_p'(bp_cfg_reg_scratch_gp):     scratch_q <= cfg_cmd_data_i;
                    cfg_addr_width_p'(bp_cfg_reg_ucode_addr_gp):
                        ucode_addr_q <= cfg_cmd_data_i[ucode_addr_width_lp-1:0];
                    cfg_addr_width_p'(bp_cfg_reg_ucode_data_gp): begin
                        ucode_w_v_q   <= 1'b1;
                        ucode_waddr_q <= ucode_addr_q;
                        ucode_wdata_q <= cfg_cmd_data_i;
                        ucode_addr_q  <= (ucode_addr_q == ucode_addr_width_lp'(ucode_els_p - 1))
                                         ? '0 : ucode_addr_q + ucode_addr_width_lp'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign freeze_o        = freeze_q;
    assign icache_mode_o   = icache_mode_q;
    assign dcache_mode_o   = dcache_mode_q;
    assign cfg_resp_data_o = resp_data_q;
    assign ucode_w_v_o     = ucode_w_v_q;
    assign ucode_addr_o    = ucode_waddr_q;
    assign ucode_data_o    = ucode_wdata_q;

endmodule

// File: tb/tb_bp_cfg_responder.sv
// Randomised bench for bp_cfg_responder against a register-map level reference model,
// plus directed scenarios with literal expectations.
module tb_bp_cfg_responder;

    localparam int CW = 8;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int UE = 256;
    localparam int UW = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [CW-1:0] my_id;
    logic          cmd_v;
    logic          cmd_ready;
    logic [CW-1:0] cmd_core;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_data;
    logic          cmd_we;
    logic          resp_v;
    logic [DW-1:0] resp_data;
    logic          yumi;
    logic          freeze;
    logic [1:0]    icm, dcm;
    logic          uw_v;
    logic [UW-1:0] uw_addr;
    logic [DW-1:0] uw_data;

    always #5 clk = ~clk;

    bp_cfg_responder dut (
        .clk_i             (clk),
        .reset_n_i         (reset_n),
        .my_core_id_i      (my_id),
        .cfg_cmd_v_i       (cmd_v),
        .cfg_cmd_ready_o   (cmd_ready),
        .cfg_cmd_core_id_i (cmd_core),
        .cfg_cmd_addr_i    (cmd_addr),
        .cfg_cmd_data_i    (cmd_data),
        .cfg_cmd_we_i      (cmd_we),
        .cfg_resp_v_o      (resp_v),
        .cfg_resp_data_o   (resp_data),
        .cfg_resp_yumi_i   (yumi),
        .freeze_o          (freeze),
        .icache_mode_o     (icm),
        .dcache_mode_o     (dcm),
        .ucode_w_v_o       (uw_v),
        .ucode_addr_o      (uw_addr),
        .ucode_data_o      (uw_data)
    );

    int n_err = 0;
    int n_chk = 0;

    // Reference model: plain register values and one pending response slot.
    int unsigned     m_freeze, m_icm, m_dcm, m_uaddr, m_uw_addr;
    longint unsigned m_scratch, m_wc, m_resp_data, m_uw_data;
    bit              m_resp_v, m_uw_v;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint unsigned m_read(input int unsigned a);
        case (a)
            'h00:    return m_freeze;
            'h01:    return longint'(my_id);
            'h02:    return m_icm;
            'h03:    return m_dcm;
            'h04:    return m_scratch;
            'h10:    return m_uaddr;
            'h20:    return m_wc;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_freeze = 1; m_icm = 0; m_dcm = 0; m_scratch = 0; m_uaddr = 0; m_wc = 0;
        m_resp_v = 0; m_resp_data = 0; m_uw_v = 0; m_uw_addr = 0; m_uw_data = 0;
    endtask

    task automatic model_step();
        bit acc;
        acc    = cmd_v && (!m_resp_v || yumi);
        m_uw_v = 0;
        if (yumi) m_resp_v = 0;
        if (acc && cmd_core == my_id) begin
            if (cmd_we) begin
                if (m_wc < 64'hFFFF_FFFF) m_wc++;
                case (int'(cmd_addr))
                    'h00: m_freeze  = cmd_data % 2;
                    'h02: m_icm     = cmd_data % 4;
                    'h03: m_dcm     = cmd_data % 4;
                    'h04: m_scratch = cmd_data;
                    'h10: m_uaddr   = cmd_data % UE;
                    'h11: begin
                        m_uw_v    = 1;
                        m_uw_addr = m_uaddr;
                        m_uw_data = cmd_data;
                        m_uaddr   = (m_uaddr + 1) % UE;
                    end
                    default: ;
                endcase
            end else begin
                m_resp_data = m_read(int'(cmd_addr));
                m_resp_v    = 1;
            end
        end
    endtask

    // One clock: drive a command, let the edge happen, advance the model, then go idle.
    task automatic cycle(input bit v, input int core, input int addr, input logic [DW-1:0] data,
                         input bit we, input bit y);
        cmd_v    = v;
        cmd_core = CW'(core);
        cmd_addr = AW'(addr);
        cmd_data = data;
        cmd_we   = we;
        yumi     = y;
        @(posedge clk);
        if (!reset_n) model_reset();
        else model_step();
        #1;
        cmd_v = 1'b0;
        yumi  = 1'b0;
    endtask

    task automatic wr(input int addr, input logic [DW-1:0] data);
        cycle(1, 3, addr, data, 1, 0);
    endtask

    task automatic rd(input int addr, input bit y);
        cycle(1, 3, addr, '0, 0, y);
    endtask

    task automatic idle(input bit y);
        cycle(0, 0, 0, '0, 0, y);
    endtask

    always @(negedge clk) begin
        chk("ready", cmd_ready, (!m_resp_v || yumi));
        chk("resp_v", resp_v, m_resp_v);
        if (m_resp_v) chk("resp_data", resp_data, m_resp_data);
        chk("freeze", freeze, m_freeze);
        chk("icache_mode", icm, m_icm);
        chk("dcache_mode", dcm, m_dcm);
        chk("ucode_w_v", uw_v, m_uw_v);
        if (m_uw_v) begin
            chk("ucode_addr", uw_addr, m_uw_addr);
            chk("ucode_data", uw_data, m_uw_data);
        end
    end

    initial begin
        int addrs[9];
        addrs = '{'h00, 'h01, 'h02, 'h03, 'h04, 'h10, 'h11, 'h20, 'h7777};
        reset_n = 1'b0;
        my_id   = CW'(3);
        cmd_v = 0; cmd_core = '0; cmd_addr = '0; cmd_data = '0; cmd_we = 0; yumi = 0;
        model_reset();
        repeat (3) idle(0);
        chk("rst_freeze", freeze, 1);
        chk("rst_icm", icm, 0);
        chk("rst_dcm", dcm, 0);
        chk("rst_resp_v", resp_v, 0);
        chk("rst_ready", cmd_ready, 1);
        @(negedge clk); #2 reset_n = 1'b1;

        wr('h00, 0);
        chk("unfreeze", freeze, 0);
        rd('h20, 0);
        chk("wc_resp_v", resp_v, 1);
        chk("wc_data", resp_data, 1);
        idle(1);

        wr('h04, 32'hA5A5_1234);
        rd('h01, 0);
        repeat (5) begin
            idle(0);
            chk("hold_v", resp_v, 1);
            chk("hold_data", resp_data, 3);
            chk("hold_ready", cmd_ready, 0);
        end
        rd('h04, 1);
        chk("b2b_v", resp_v, 1);
        chk("b2b_data", resp_data, 32'hA5A5_1234);
        idle(1);

        cycle(1, 5, 'h02, 32'h3, 1, 0);
        cycle(1, 5, 'h04, 32'h0, 0, 0);
        chk("other_core_resp", resp_v, 0);
        chk("other_core_icm", icm, 0);
        rd('h04, 0);
        chk("other_core_scratch", resp_data, 32'hA5A5_1234);
        idle(1);

        wr('h10, 254);
        chk("uaddr_no_pulse", uw_v, 0);
        wr('h11, 32'hAAAA_0001);
        chk("ucodeA_v", uw_v, 1);
        chk("ucodeA_addr", uw_addr, 254);
        chk("ucodeA_data", uw_data, 32'hAAAA_0001);
        wr('h11, 32'hBBBB_0002);
        chk("ucodeB_addr", uw_addr, 255);
        chk("ucodeB_data", uw_data, 32'hBBBB_0002);
        wr('h11, 32'hCCCC_0003);
        chk("ucodeC_addr", uw_addr, 0);
        chk("ucodeC_data", uw_data, 32'hCCCC_0003);
        idle(0);
        chk("ucode_pulse_end", uw_v, 0);

        wr('h02, 32'hFFFF_FFFF);
        chk("icm_trunc", icm, 3);
        rd('h02, 0);
        chk("icm_read", resp_data, 3);
        rd('h7777, 1);
        chk("unmapped_read", resp_data, 0);
        idle(1);
        wr('h01, 32'h9);
        rd('h01, 0);
        chk("ro_ignored", resp_data, 3);
        idle(1);

        rd('h04, 0);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_resp_v", resp_v, 0);
        chk("mid_rst_freeze", freeze, 1);
        chk("mid_rst_icm", icm, 0);
        chk("mid_rst_ready", cmd_ready, 1);
        idle(0);
        idle(0);
        @(negedge clk); #2 reset_n = 1'b1;
        rd('h04, 0);
        chk("rst_scratch", resp_data, 0);
        rd('h10, 1);
        chk("rst_uaddr", resp_data, 0);
        rd('h20, 1);
        chk("rst_wc", resp_data, 0);
        idle(1);

        for (int i = 0; i < 3000; i++) begin
            int core, addr;
            core = ($urandom_range(0, 9) < 8) ? 3 : int'($urandom_range(0, 255));
            addr = ($urandom_range(0, 9) < 9) ? addrs[$urandom_range(0, 8)]
                                             : int'($urandom_range(0, 16'hFFFF));
            cycle($urandom_range(0, 9) < 7, core, addr, $urandom, $urandom_range(0, 1) == 1,
                  m_resp_v && ($urandom_range(0, 2) != 0));
        end
        idle(m_resp_v);
        idle(0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
